// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_COMMIT = 2'd1,
        SRC_EXEC   = 2'd2,
        SRC_DEC    = 2'd3
    } redirect_src_t;

    localparam int unsigned INST_BYTES = 4;

    // Only backend-originated redirects kill in-flight work.
    function automatic logic src_flushes(input redirect_src_t src);
        return (src == SRC_COMMIT) || (src == SRC_EXEC);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch request bundle between fetch_ctrl (master) and the instruction queue (slave).
interface fetch_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic                   fetch_valid;
    logic [FETCH_WIDTH-1:0] fetch_mask;
    logic                   iq_ready;

    modport master (output fetch_pc, output fetch_valid, output fetch_mask, input iq_ready);
    modport slave  (input fetch_pc, input fetch_valid, input fetch_mask, output iq_ready);
endinterface

// File: rtl/fetch_ctrl_redirect_arb.sv
// Fixed-priority redirect selector: commit beats exec beats decode; target is word-aligned.
module fetch_redirect_arb
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  commit_valid,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  exec_valid,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic                  dec_valid,
    input  logic [ADDR_WIDTH-1:0] dec_addr,
    output logic                  win_valid,
    output redirect_src_t         win_src,
    output logic [ADDR_WIDTH-1:0] win_addr
);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // Priority mux over the three redirect sources.
    always_comb begin
        win_valid = 1'b0;
        win_src   = SRC_NONE;
        win_addr  = {ADDR_WIDTH{1'b0}};
        if (commit_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_COMMIT;
            win_addr  = commit_addr & ALIGN_MASK;
        end else if (exec_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_EXEC;
            win_addr  = exec_addr & ALIGN_MASK;
        end else if (dec_valid) begin
            win_valid = 1'b1;
            win_src   = SRC_DEC;
            win_addr  = dec_addr & ALIGN_MASK;
        end else begin
            win_valid = 1'b0;
            win_src   = SRC_NONE;
            win_addr  = {ADDR_WIDTH{1'b0}};
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer with prioritized, flush-aware redirects.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int FETCH_WIDTH  = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  commit_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] commit_redirect_addr,
    input  logic                  exec_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] exec_redirect_addr,
    input  logic                  dec_jump_valid,
    input  logic [ADDR_WIDTH-1:0] dec_jump_addr,
    input  logic                  halt_req,
    fetch_ctrl_if.master          bus,
    output logic                  flush,
    output logic [1:0]            state_o,
    output logic [31:0]           perf_bundles,
    output logic [31:0]           perf_stalls,
    output logic [31:0]           perf_redirects
);
    localparam int SLOT_W = $clog2(FETCH_WIDTH);
    localparam int CNT_W  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    fetch_state_t          state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  flush_r;

    logic                  win_valid_s;
    redirect_src_t         win_src_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic                  take_s;
    logic                  valid_s;
    logic                  accept_s;
    logic [SLOT_W-1:0]     slot_s;
    logic [SLOT_W:0]       lanes_s;
    logic [ADDR_WIDTH-1:0] step_s;
    logic [FETCH_WIDTH-1:0] mask_s;

    fetch_redirect_arb #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
        .commit_valid (commit_redirect_valid),
        .commit_addr  (commit_redirect_addr),
        .exec_valid   (exec_redirect_valid),
        .exec_addr    (exec_redirect_addr),
        .dec_valid    (dec_jump_valid),
        .dec_addr     (dec_jump_addr),
        .win_valid    (win_valid_s),
        .win_src      (win_src_s),
        .win_addr     (win_addr_s)
    );

    assign valid_s  = (state_r == ST_RUN);
    assign accept_s = valid_s && bus.iq_ready;
    assign slot_s   = pc_r[SLOT_W+1:2];
    assign lanes_s  = (SLOT_W+1)'(FETCH_WIDTH) - {1'b0, slot_s};
    assign step_s   = {{(ADDR_WIDTH-SLOT_W-3){1'b0}}, lanes_s, 2'b00};

    // Lane mask stops at the bundle-aligned boundary; zero while no request is issued.
    always_comb begin
        mask_s = {FETCH_WIDTH{1'b0}};
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask_s[i] = valid_s && ((SLOT_W+1)'(i) < lanes_s);
        end
    end

    // Which states honour the arbitrated redirect (HALT only wakes on commit).
    always_comb begin
        case (state_r)
            ST_BOOT:  take_s = 1'b0;
            ST_RUN:   take_s = win_valid_s;
            ST_FLUSH: take_s = win_valid_s;
            ST_HALT:  take_s = win_valid_s && (win_src_s == SRC_COMMIT);
            default:  take_s = 1'b0;
        endcase
    end

    // Sequencing FSM: state, PC, bubble counter and flush pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BOOT;
            pc_r    <= {ADDR_WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            flush_r <= 1'b0;
        end else begin
            flush_r <= 1'b0;
            if (take_s) begin
                state_r <= ST_FLUSH;
                pc_r    <= win_addr_s;
                cnt_r   <= CNT_W'(FLUSH_CYCLES);
                flush_r <= src_flushes(win_src_s);
            end else begin
                case (state_r)
                    ST_BOOT: begin
                        pc_r    <= start_addr & ALIGN_MASK;
                        state_r <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (halt_req) begin
                            state_r <= ST_HALT;
                        end else if (accept_s) begin
                            pc_r <= pc_r + step_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end
                    ST_FLUSH: begin
                        if (cnt_r <= CNT_W'(1)) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_RUN;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                    ST_HALT: state_r <= ST_HALT;
                    default: state_r <= ST_BOOT;
                endcase
            end
        end
    end

    assign bus.fetch_pc    = pc_r;
    assign bus.fetch_valid = valid_s;
    assign bus.fetch_mask  = mask_s;
    assign flush           = flush_r;
    assign state_o         = state_r;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] bundles_r;
    logic [31:0] stalls_r;
    logic [31:0] redirects_r;

    // Free-running wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            bundles_r   <= 32'd0;
            stalls_r    <= 32'd0;
            redirects_r <= 32'd0;
        end else begin
            if (accept_s) bundles_r <= bundles_r + 32'd1;
            else          bundles_r <= bundles_r;
            if (valid_s && !bus.iq_ready) stalls_r <= stalls_r + 32'd1;
            else                          stalls_r <= stalls_r;
            if (take_s) redirects_r <= redirects_r + 32'd1;
            else        redirects_r <= redirects_r;
        end
    end

    assign perf_bundles   = bundles_r;
    assign perf_stalls    = stalls_r;
    assign perf_redirects = redirects_r;
`else
    assign perf_bundles   = 32'd0;
    assign perf_stalls    = 32'd0;
    assign perf_redirects = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl (ADDR_WIDTH=32, FETCH_WIDTH=2, FLUSH_CYCLES=1).
module tb_fetch_ctrl;
    import fetch_pkg::*;

    typedef struct packed {
        logic [1:0]  st;
        logic        v;
        logic [31:0] pc;
        logic [1:0]  m;
        logic        f;
    } obs_t;

    typedef struct packed {
        logic        rs;
        logic        rdy;
        logic        hl;
        logic [2:0]  rv;
        logic [31:0] ca;
        logic [31:0] ea;
        logic [31:0] da;
        obs_t        e;
    } row_t;

    logic        clk;
    logic        rst;
    logic [31:0] start_addr;
    logic        commit_redirect_valid, exec_redirect_valid, dec_jump_valid, halt_req;
    logic [31:0] commit_redirect_addr, exec_redirect_addr, dec_jump_addr;
    logic        flush;
    logic [1:0]  state_o;
    logic [31:0] perf_bundles, perf_stalls, perf_redirects;

    fetch_ctrl_if #(.ADDR_WIDTH(32), .FETCH_WIDTH(2)) bus ();

    fetch_ctrl #(.ADDR_WIDTH(32), .FETCH_WIDTH(2), .FLUSH_CYCLES(1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_addr            (start_addr),
        .commit_redirect_valid (commit_redirect_valid),
        .commit_redirect_addr  (commit_redirect_addr),
        .exec_redirect_valid   (exec_redirect_valid),
        .exec_redirect_addr    (exec_redirect_addr),
        .dec_jump_valid        (dec_jump_valid),
        .dec_jump_addr         (dec_jump_addr),
        .halt_req              (halt_req),
        .bus                   (bus),
        .flush                 (flush),
        .state_o               (state_o),
        .perf_bundles          (perf_bundles),
        .perf_stalls           (perf_stalls),
        .perf_redirects        (perf_redirects)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    row_t rows[$];
    obs_t exp_q[$];
    obs_t got_s, exp_s;
    int   total = 0;
    int   bad   = 0;

    function automatic obs_t o(input logic [1:0] st, input logic v, input logic [31:0] pc,
                               input logic [1:0] m, input logic f);
        return '{st, v, pc, m, f};
    endfunction

    function automatic row_t rw(input logic rs, input logic rdy, input logic hl, input logic [2:0] rv,
                                input logic [31:0] ca, input logic [31:0] ea, input logic [31:0] da,
                                input obs_t e);
        return '{rs, rdy, hl, rv, ca, ea, da, e};
    endfunction

    task automatic drive(input row_t r);
        rst                   = r.rs;
        bus.iq_ready          = r.rdy;
        halt_req              = r.hl;
        commit_redirect_valid = r.rv[2];
        exec_redirect_valid   = r.rv[1];
        dec_jump_valid        = r.rv[0];
        commit_redirect_addr  = r.ca;
        exec_redirect_addr    = r.ea;
        dec_jump_addr         = r.da;
    endtask

    task automatic test_reset();
        rows.push_back(rw(1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_BOOT, 1'b0, 32'h0, 2'b00, 1'b0)));
        rows.push_back(rw(1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_BOOT, 1'b0, 32'h0, 2'b00, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL reset[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
        total++;
        if ({perf_bundles, perf_stalls, perf_redirects} !== 96'd0) begin
            bad++;
            $display("FAIL reset_perf got %0d/%0d/%0d want 0/0/0", perf_bundles, perf_stalls, perf_redirects);
        end
    endtask

    task automatic test_boot_run();
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h100, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h108, 2'b11, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL boot_run[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] want_b, want_s;
        for (int k = 0; k < 3; k++)
            rows.push_back(rw(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h108, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h110, 2'b11, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL backpressure[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
`ifdef FETCH_CTRL_PERF_EN
        want_b = 32'd2;
        want_s = 32'd3;
`else
        want_b = 32'd0;
        want_s = 32'd0;
`endif
        total++;
        if (perf_bundles !== want_b || perf_stalls !== want_s) begin
            bad++;
            $display("FAIL perf_stall got bundles=%0d stalls=%0d want bundles=%0d stalls=%0d",
                     perf_bundles, perf_stalls, want_b, want_s);
        end
    endtask

    task automatic test_misaligned();
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h204, 32'h0, o(ST_FLUSH, 1'b0, 32'h204, 2'b00, 1'b1)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h204, 2'b01, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h208, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h210, 2'b11, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL misaligned[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
    endtask

    task automatic test_priority();
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b111, 32'h400, 32'h300, 32'h200, o(ST_FLUSH, 1'b0, 32'h400, 2'b00, 1'b1)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h400, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h200, o(ST_FLUSH, 1'b0, 32'h200, 2'b00, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h31F, 32'h0, o(ST_FLUSH, 1'b0, 32'h31C, 2'b00, 1'b1)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h31C, 2'b01, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h320, 2'b11, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL priority[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
    endtask

    task automatic test_halt();
        logic [31:0] want_r;
        rows.push_back(rw(1'b0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_HALT, 1'b0, 32'h320, 2'b00, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_HALT, 1'b0, 32'h320, 2'b00, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h500, 32'h0, o(ST_HALT, 1'b0, 32'h320, 2'b00, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h600, o(ST_HALT, 1'b0, 32'h320, 2'b00, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b1, 3'b100, 32'h82, 32'h0, 32'h0, o(ST_FLUSH, 1'b0, 32'h80, 2'b00, 1'b1)));
        rows.push_back(rw(1'b0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h80, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h88, 2'b11, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL halt[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
`ifdef FETCH_CTRL_PERF_EN
        want_r = 32'd5;
`else
        want_r = 32'd0;
`endif
        total++;
        if (perf_redirects !== want_r) begin
            bad++;
            $display("FAIL perf_redirects got %0d want %0d", perf_redirects, want_r);
        end
    endtask

    task automatic test_wrap_reset();
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFF8, 32'h0, o(ST_FLUSH, 1'b0, 32'hFFFF_FFF8, 2'b00, 1'b1)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'hFFFF_FFF8, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h0000_0000, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h600, 32'h0, o(ST_FLUSH, 1'b0, 32'h600, 2'b00, 1'b1)));
        rows.push_back(rw(1'b1, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_BOOT, 1'b0, 32'h0, 2'b00, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b100, 32'h700, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h100, 2'b11, 1'b0)));
        rows.push_back(rw(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, o(ST_RUN, 1'b1, 32'h108, 2'b11, 1'b0)));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            exp_q.push_back(rows[i].e);
            @(posedge clk); #1;
            exp_s = exp_q.pop_front();
            got_s = '{state_o, bus.fetch_valid, bus.fetch_pc, bus.fetch_mask, flush};
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL wrap_reset[%0d] got st=%0d v=%b pc=%h m=%b f=%b want st=%0d v=%b pc=%h m=%b f=%b",
                         i, got_s.st, got_s.v, got_s.pc, got_s.m, got_s.f, exp_s.st, exp_s.v, exp_s.pc, exp_s.m, exp_s.f);
            end
        end
        rows.delete();
    endtask

    initial begin
        rst                   = 1'b1;
        start_addr            = 32'h100;
        bus.iq_ready          = 1'b1;
        halt_req              = 1'b0;
        commit_redirect_valid = 1'b0;
        exec_redirect_valid   = 1'b0;
        dec_jump_valid        = 1'b0;
        commit_redirect_addr  = 32'h0;
        exec_redirect_addr    = 32'h0;
        dec_jump_addr         = 32'h0;
        #1;
        test_reset();
        test_boot_run();
        test_backpressure();
        test_misaligned();
        test_priority();
        test_halt();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
